// File: rtl/ercm_mul_arbiter.sv
// Round-robin sharing of one combinational ERCM8 multiplier among N_REQ requesters.
// Operands are held for SETTLE_CYCLES clocks, then the product is registered and returned.
module ercm_mul_arbiter #(
  parameter int N_REQ         = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int MASK_W        = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [8*N_REQ-1:0]         req_a,
  input  logic [8*N_REQ-1:0]         req_b,
  input  logic                       cfg_we,
  input  logic [$clog2(N_REQ)-1:0]   cfg_id,
  input  logic [MASK_W-1:0]          cfg_mask,
  output logic [7:0]                 mul_a,
  output logic [7:0]                 mul_b,
  output logic [MASK_W-1:0]          mul_mask,
  input  logic [15:0]                mul_p,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [15:0]                rsp_p,
  output logic [15:0]                op_count
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic [IDW-1:0]    ptr;
  logic [CW-1:0]     cnt;
  logic [MASK_W-1:0] mask_q [N_REQ];

  logic [IDW-1:0]    win;
  logic              win_vld;
  logic [IDW-1:0]    idx;
  logic [N_REQ-1:0]  win_oh;
  logic [7:0]        lane_a;
  logic [7:0]        lane_b;
  logic [IDW-1:0]    ptr_nxt;

  // first valid requester at or above ptr, wrapping
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % N_REQ);
      if (!win_vld && req_valid[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  always_comb begin
    win_oh = '0;
    if (!rst && state == IDLE && win_vld)
      win_oh[win] = 1'b1;
  end

  assign req_ready = win_oh;
  assign lane_a    = req_a[{win, 3'b000} +: 8];
  assign lane_b    = req_b[{win, 3'b000} +: 8];
  assign ptr_nxt   = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_mask  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
      op_count  <= '0;
      for (int i = 0; i < N_REQ; i++)
        mask_q[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            mul_a    <= lane_a;
            mul_b    <= lane_b;
            mul_mask <= mask_q[win];
            rsp_id   <= win;
            ptr      <= ptr_nxt;
            cnt      <= CNT_INIT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_p     <= mul_p;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (op_count != 16'hFFFF)
              op_count <= op_count + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // grant above reads the old mask; a same-edge write lands for the next grant
      if (cfg_we && int'(cfg_id) < N_REQ)
        mask_q[cfg_id] <= cfg_mask;
    end
  end

endmodule

// File: tb/tb_ercm_mul_arbiter.sv
// Bench for ercm_mul_arbiter: transaction-level model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ercm_mul_arbiter;

  localparam int N  = 4;
  localparam int S  = 3;
  localparam int MW = 7;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [8*N-1:0]  req_a;
  logic [8*N-1:0]  req_b;
  logic            cfg_we;
  logic [IW-1:0]   cfg_id;
  logic [MW-1:0]   cfg_mask;
  logic [7:0]      mul_a;
  logic [7:0]      mul_b;
  logic [MW-1:0]   mul_mask;
  logic [15:0]     mul_p;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [15:0]     rsp_p;
  logic [15:0]     op_count;

  always #5 clk = ~clk;

  ercm_mul_arbiter #(.N_REQ(N), .SETTLE_CYCLES(S), .MASK_W(MW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_mask(cfg_mask),
    .mul_a(mul_a), .mul_b(mul_b), .mul_mask(mul_mask), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .op_count(op_count)
  );

  // multiplier stub: garbage until operands have settled S-1 edges
  int age = 1000;
  always @(posedge clk) begin
    if ((req_ready & req_valid) != '0) age <= 0;
    else if (age < 1000) age <= age + 1;
  end
  assign mul_p = (age >= S - 1) ?
    16'(mul_a) * 16'(mul_b) + 16'(mul_mask) : 16'hDEAD;

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model, transaction level
  bit          m_idle = 1'b1;
  bit          m_resp = 1'b0;
  int          m_ptr  = 0;
  int          m_due  = 0;
  int          m_id   = 0;
  logic [7:0]  m_a    = '0;
  logic [7:0]  m_b    = '0;
  logic [MW-1:0] m_mask = '0;
  logic [MW-1:0] m_masks [N];
  logic [15:0] m_p    = '0;
  logic [15:0] m_cnt  = '0;
  int          cyc    = 0;

  // DUT activity log
  int g_cyc[$];
  int g_id[$];
  int r_cyc[$];
  int r_id[$];
  int r_p[$];
  int r_mask[$];

  logic            s_rst;
  logic [N-1:0]    s_valid;
  logic [8*N-1:0]  s_a;
  logic [8*N-1:0]  s_b;
  logic            s_rr;
  logic            s_we;
  logic [IW-1:0]   s_id;
  logic [MW-1:0]   s_mask;
  logic [N-1:0]    s_grant;
  logic            s_acc;
  logic [IW-1:0]   s_rid;
  logic [15:0]     s_rp;
  logic [MW-1:0]   s_mm;

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int qget(int q[$], int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_log();
    g_cyc.delete(); g_id.delete();
    r_cyc.delete(); r_id.delete(); r_p.delete(); r_mask.delete();
  endtask

  task automatic model_update();
    int w;
    if (s_rst) begin
      m_idle = 1'b1; m_resp = 1'b0; m_ptr = 0; m_id = 0;
      m_a = '0; m_b = '0; m_mask = '0; m_p = '0; m_cnt = '0;
      for (int i = 0; i < N; i++) m_masks[i] = '0;
    end else begin
      cyc++;
      if (s_grant != '0) begin
        for (int i = 0; i < N; i++)
          if (s_grant[i]) begin g_cyc.push_back(cyc); g_id.push_back(i); end
      end
      if (s_acc) begin
        r_cyc.push_back(cyc); r_id.push_back(int'(s_rid));
        r_p.push_back(int'(s_rp)); r_mask.push_back(int'(s_mm));
      end
      if (m_idle) begin
        w = rr_pick(s_valid, m_ptr);
        if (w >= 0) begin
          m_idle = 1'b0;
          m_id   = w;
          m_a    = s_a[8*w +: 8];
          m_b    = s_b[8*w +: 8];
          m_mask = m_masks[w];
          m_ptr  = (w + 1) % N;
          m_due  = cyc + S;
        end
      end else if (!m_resp) begin
        if (cyc == m_due) begin
          m_resp = 1'b1;
          m_p    = 16'(m_a) * 16'(m_b) + 16'(m_mask);
        end
      end else if (s_rr) begin
        m_resp = 1'b0;
        m_idle = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (s_we && int'(s_id) < N) m_masks[s_id] = s_mask;
    end
  endtask

  task automatic compare();
    int w;
    logic [N-1:0] er;
    w  = rr_pick(req_valid, m_ptr);
    er = '0;
    if (!rst && m_idle && w >= 0) er[w] = 1'b1;
    check("req_ready", req_ready, er);
    check("mul_a", mul_a, m_a);
    check("mul_b", mul_b, m_b);
    check("mul_mask", mul_mask, m_mask);
    check("rsp_valid", rsp_valid, m_resp);
    check("rsp_id", rsp_id, m_id);
    check("rsp_p", rsp_p, m_p);
    check("op_count", op_count, m_cnt);
  endtask

  task automatic step();
    #1;
    s_rst = rst; s_valid = req_valid; s_a = req_a; s_b = req_b;
    s_rr = rsp_ready; s_we = cfg_we; s_id = cfg_id; s_mask = cfg_mask;
    s_grant = req_ready & req_valid;
    s_acc = rsp_valid && rsp_ready;
    s_rid = rsp_id; s_rp = rsp_p; s_mm = mul_mask;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_masks[i] = '0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    cfg_we = 1'b0; cfg_id = '0; cfg_mask = '0; rsp_ready = 1'b1;
    @(negedge clk);
    step(); step();
    check("reset_op_count", op_count, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_req_ready", req_ready, 0);
    rst = 1'b0;

    // single request
    clear_log();
    req_a[7:0] = 8'd200; req_b[7:0] = 8'd150; req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (8) step();
    check("t1_grants", g_cyc.size(), 1);
    check("t1_rsp_id", qget(r_id, 0), 0);
    check("t1_rsp_p", qget(r_p, 0), 30000);
    check("t1_latency", qget(r_cyc, 0) - qget(g_cyc, 0), S + 1);
    check("t1_op_count", op_count, 1);

    // all four continuously
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8] = 8'(i + 1);
      req_b[8*i +: 8] = 8'd10;
    end
    clear_log();
    req_valid = 4'hF;
    repeat (25) step();
    req_valid = '0;
    repeat (3) step();
    begin
      int eid [5] = '{0, 1, 2, 3, 0};
      int ep  [5] = '{10, 20, 30, 40, 10};
      check("t2_rsp_count", r_id.size(), 5);
      for (int i = 0; i < 5; i++) begin
        check("t2_rsp_id", qget(r_id, i), eid[i]);
        check("t2_rsp_p", qget(r_p, i), ep[i]);
      end
      for (int i = 0; i < 4; i++)
        check("t2_grant_gap", qget(g_cyc, i + 1) - qget(g_cyc, i), 5);
    end

    // mask write on the same edge as the grant to that requester
    clear_log();
    req_valid = 4'b0100;
    cfg_we = 1'b1; cfg_id = 2'd2; cfg_mask = 7'h7F;
    step();
    cfg_we = 1'b0;
    repeat (9) step();
    req_valid = '0;
    repeat (3) step();
    check("t3_mask_first", qget(r_mask, 0), 0);
    check("t3_mask_second", qget(r_mask, 1), 127);
    check("t3_p_first", qget(r_p, 0), 30);
    check("t3_p_second", qget(r_p, 1), 157);

    // backpressure
    clear_log();
    req_a[7:0] = 8'd200; req_b[7:0] = 8'd150;
    req_valid = 4'b0001; rsp_ready = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 6; i++) begin
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_p", rsp_p, 30000);
      check("t4_hold_id", rsp_id, 0);
      check("t4_hold_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    step();
    req_valid = '0;
    check("t4_regrant_gap", qget(g_cyc, 1) - qget(g_cyc, 0), 11);
    check("t4_rsp_p", qget(r_p, 0), 30000);
    repeat (6) step();

    // reset in the middle of an operation
    clear_log();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_mul_a", mul_a, 0);
    check("t5_mul_b", mul_b, 0);
    check("t5_mul_mask", mul_mask, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_op_count", op_count, 0);
    repeat (5) step();
    check("t5_no_rsp", r_id.size(), 0);
    req_a[15:8] = 8'd7; req_b[15:8] = 8'd9;
    req_valid = 4'b0011;
    step();
    req_valid = 4'b0010;
    repeat (6) step();
    req_valid = '0;
    repeat (6) step();
    check("t5_ptr_restart", qget(r_id, 0), 0);
    check("t5_next_id", qget(r_id, 1), 1);
    check("t5_next_p", qget(r_p, 1), 63);
    check("t5_op_count_after", op_count, 2);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      req_valid = N'($urandom);
      req_a     = 32'($urandom);
      req_b     = 32'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_id    = IW'($urandom);
      cfg_mask  = MW'($urandom);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; req_valid = '0; cfg_we = 1'b0; rsp_ready = 1'b1;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ercm_mul_arbiter.md
# ercm_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational ERCM8 approximate multiplier (8x8 operands, 7-bit accuracy mask, 16-bit product) among N_REQ requesters. The multiplier path is treated as a multi-cycle path:
- operands and mask are held stable in registers for SETTLE_CYCLES clocks;
- the product is then captured and returned with the requester ID.

The block also holds one programmable accuracy mask per requester and counts completed operations. It sits between requester logic and the ERCM8_1 instance.

## Interface
- N_REQ, 4, number of requesters (2..8)
- SETTLE_CYCLES, 3, clocks from operand register load to product capture (>=1)
- MASK_W, 7, mask width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  N_REQ  request pending, bit i = requester i
- req_ready  out  N_REQ  grant; one-hot or zero
- req_a  in  8*N_REQ  operand A, lane i = [8i+7:8i]
- req_b  in  8*N_REQ  operand B, same packing
- cfg_we  in  1  mask write strobe
- cfg_id  in  $clog2(N_REQ)  mask register select
- cfg_mask  in  MASK_W  mask write data
- mul_a  out  8  to multiplier dat_in_a (registered)
- mul_b  out  8  to multiplier dat_in_b (registered)
- mul_mask  out  MASK_W  to multiplier mask (registered)
- mul_p  in  16  from multiplier dat_o
- rsp_valid  out  1  result available
- rsp_ready  in  1  result accepted
- rsp_id  out  $clog2(N_REQ)  requester of result
- rsp_p  out  16  captured product
- op_count  out  16  completed operations, saturating

## Operation
- Reset values:
  - state IDLE, rr pointer 0, all mask registers 0;
  - mul_a/mul_b/mul_mask 0;
  - rsp_valid 0, rsp_id 0, rsp_p 0, op_count 0;
  - req_ready 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Winner is the first i with req_valid[i]=1, searching from pointer upward and wrapping.
  - req_ready asserted combinationally for the winner only. No valid requests → req_ready=0, stay IDLE.
  - On the handshake edge:
    - mul_a/mul_b ← lane of winner;
    - mul_mask ← mask[winner];
    - rsp_id ← winner;
    - pointer ← winner+1 mod N_REQ;
    - counter ← SETTLE_CYCLES-1;
    - state → WAIT.
- WAIT:
  - req_ready=0; mul_* held constant.
  - Counter decrements each edge.
  - On the edge where counter==0: rsp_p ← mul_p, rsp_valid ← 1, state → RESP.
- RESP:
  - req_ready=0; rsp_valid, rsp_id and rsp_p held stable.
  - On the edge with rsp_ready=1: rsp_valid ← 0, op_count ← op_count+1 (saturates at 16'hFFFF), state → IDLE.
  - mul_* keep their last values until the next grant.
- Mask config:
  - cfg_we writes mask[cfg_id] at the edge; accepted in any state.
  - A grant on the same edge to the same ID latches the old mask; the new mask applies from the next grant.
- Requester deasserting req_valid before a grant: no grant issued; no effect.
- cfg_id >= N_REQ: write ignored.

## Timing
- Handshake at edge k: mul_* valid after edge k. mul_p sampled at edge k+SETTLE_CYCLES. rsp_valid high from edge k+SETTLE_CYCLES.
- Minimum spacing between grants is SETTLE_CYCLES+2 edges, with rsp_ready tied high.
- No combinational path from mul_p to any output; rsp_p is registered only.
- rst asserted at any time:
  - all registers take their reset values immediately;
  - an in-flight operation is discarded: no rsp_valid, op_count unchanged from 0;
  - first grant possible at the first edge after rst deasserts.

## Test plan
- Single request, mask 0. Bench stub drives mul_p = mul_a*mul_b after SETTLE_CYCLES-1 edges, X before.
  - Stimulus: req_valid=4'b0001, A=200, B=150, rsp_ready=1.
  - Required: req_ready[0] for 1 cycle; rsp_p=30000 and rsp_id=0 at handshake+3 edges; op_count=1.
- All four valid continuously, rsp_ready=1, distinct operands per lane (A=i+1, B=10):
  - responses in order id 0,1,2,3,0;
  - products 10,20,30,40,10;
  - grants exactly 5 edges apart.
- Mask config collision: cfg_we=1, cfg_id=2, cfg_mask=7'h7F on the same edge as the grant to requester 2.
  - That op drives mul_mask=0.
  - The next op for requester 2 drives mul_mask=7'h7F.
- Backpressure: rsp_ready=0 for 6 cycles while RESP with rsp_p=30000.
  - rsp_valid, rsp_p and rsp_id stable throughout; req_ready=0 throughout.
  - Acceptance on the 7th cycle; next grant follows in IDLE.
- Reset mid-operation: rst pulsed 1 cycle during WAIT of the first op.
  - mul_a/mul_b/mul_mask=0, rsp_valid stays 0, op_count=0, pointer restarts at 0.
  - Next request from id 1 granted normally.
